// File: rtl/lock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lock_ctrl_pkg
//  Description : Shared constants, key bit map and FSM state encoding for the
//                key-locked SEC/DED corrector sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package lock_ctrl_pkg;

   localparam int KEY_W  = 14;
   localparam int MUX_W  = 4;
   localparam int XOR_W  = 10;
   localparam int CNT_W  = 4;

   // Key vector layout: mux selects in the low nibble, XOR gates above.
   localparam int P1_IDX  = 0;
   localparam int P2_IDX  = 1;
   localparam int P3_IDX  = 2;
   localparam int P4_IDX  = 3;
   localparam int X1_IDX  = 4;
   localparam int X2_IDX  = 5;
   localparam int X3_IDX  = 6;
   localparam int X4_IDX  = 7;
   localparam int X5_IDX  = 8;
   localparam int X6_IDX  = 9;
   localparam int X7_IDX  = 10;
   localparam int X8_IDX  = 11;
   localparam int X9_IDX  = 12;
   localparam int X10_IDX = 13;

   typedef enum logic [2:0] {
      NOKEY = 3'd0,
      ARMED = 3'd1,
      DRIVE = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/lock_key_eval_ctrl_key_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : key_shift_reg
//  Description : Serial key shadow register with length check. Produces a
//                registered commit strobe plus a frozen copy of the complete
//                key, or a one-cycle length error pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module key_shift_reg
   import lock_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_accept,
   input  logic             i_key_bit,
   input  logic             i_key_last,
   output logic             o_commit,
   output logic [KEY_W-1:0] o_commit_key,
   output logic             o_err_len
);

   logic [KEY_W-1:0] shadow_q, shadow_d;
   logic [KEY_W-1:0] commit_key_q, commit_key_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             commit_q, commit_d;
   logic             err_q, err_d;
   logic [KEY_W-1:0] w_shifted;
   logic             w_full;

   // Insert the incoming bit at position cnt and judge the key length.
   always_comb begin
      w_shifted        = shadow_q;
      w_shifted[cnt_q] = i_key_bit;
      w_full           = (cnt_q == CNT_W'(KEY_W - 1));
      shadow_d         = shadow_q;
      cnt_d            = cnt_q;
      commit_key_d     = commit_key_q;
      commit_d         = 1'b0;
      err_d            = 1'b0;
      if (i_accept) begin
         if (i_key_last && w_full) begin
            // Freeze the full key separately so bits arriving during the
            // commit cycle cannot disturb what the parent copies.
            commit_d     = 1'b1;
            commit_key_d = w_shifted;
            shadow_d     = '0;
            cnt_d        = '0;
         end else if (i_key_last || w_full) begin
            err_d    = 1'b1;
            shadow_d = '0;
            cnt_d    = '0;
         end else begin
            shadow_d = w_shifted;
            cnt_d    = cnt_q + CNT_W'(1);
         end
      end
   end

   // Shadow, counter and strobe registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q     <= '0;
         commit_key_q <= '0;
         cnt_q        <= '0;
         commit_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         commit_key_q <= commit_key_d;
         cnt_q        <= cnt_d;
         commit_q     <= commit_d;
         err_q        <= err_d;
      end
   end

   assign o_commit     = commit_q;
   assign o_commit_key = commit_key_q;
   assign o_err_len    = err_q;

endmodule
`default_nettype wire

// File: rtl/lock_key_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lock_key_eval_ctrl
//  Description : Serially loads and atomically commits the 14-bit unlock key,
//                then sequences evaluation requests through the combinational
//                locked corrector core with a valid/ready result port.
//  Revision    : 1.0  initial release
// ============================================================================
module lock_key_eval_ctrl
   import lock_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   input  logic              key_bit,
   input  logic              key_last,
   output logic              key_ready,
   output logic              key_loaded,
   output logic              err_len,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic [7:0]        in_chk,
   output logic              in_ready,
   output logic              out_valid,
   output logic [31:0]       out_data,
   input  logic              out_ready,
   output logic [MUX_W-1:0]  core_p,
   output logic [XOR_W-1:0]  core_x,
   output logic [31:0]       core_d,
   output logic [7:0]        core_c,
   output logic              core_en,
   input  logic [31:0]       core_q
);

   state_e           state_q, state_d;
   logic [MUX_W-1:0] key_p_q, key_p_d;
   logic [XOR_W-1:0] key_x_q, key_x_d;
   logic             key_loaded_q, key_loaded_d;
   logic [31:0]      core_d_q, core_d_d;
   logic [7:0]       core_c_q, core_c_d;
   logic             core_en_q, core_en_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_data_q, out_data_d;

   logic             w_commit;
   logic [KEY_W-1:0] w_commit_key;
   logic             w_key_accept;

   // Keys are only taken while no evaluation is in flight; a pending commit
   // blocks new requests so the core never sees a key swap mid-evaluation.
   assign key_ready    = !rst && ((state_q == NOKEY) || (state_q == ARMED));
   assign in_ready     = !rst && (state_q == ARMED) && !key_valid && !w_commit;
   assign w_key_accept = key_valid && key_ready;

   key_shift_reg u_key_shift_reg (
      .clk          (clk),
      .rst          (rst),
      .i_accept     (w_key_accept),
      .i_key_bit    (key_bit),
      .i_key_last   (key_last),
      .o_commit     (w_commit),
      .o_commit_key (w_commit_key),
      .o_err_len    (err_len)
   );

   // Next-state and datapath update: key commit, request launch, settle
   // countdown, result capture and result handshake.
   always_comb begin
      state_d      = state_q;
      key_p_d      = key_p_q;
      key_x_d      = key_x_q;
      key_loaded_d = key_loaded_q;
      core_d_d     = core_d_q;
      core_c_d     = core_c_q;
      core_en_d    = core_en_q;
      settle_d     = settle_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;

      if (w_commit) begin
         key_p_d      = w_commit_key[P4_IDX:P1_IDX];
         key_x_d      = w_commit_key[X10_IDX:X1_IDX];
         key_loaded_d = 1'b1;
      end

      case (state_q)
         NOKEY: begin
            if (w_commit) state_d = ARMED;
         end
         ARMED: begin
            if (in_valid && in_ready) begin
               core_d_d  = in_data;
               core_c_d  = in_chk;
               core_en_d = 1'b1;
               settle_d  = CNT_W'(SETTLE);
               state_d   = DRIVE;
            end
         end
         DRIVE, WAIT: begin
            if (settle_q == '0) begin
               out_data_d  = core_q;
               out_valid_d = 1'b1;
               core_en_d   = 1'b0;
               state_d     = RESP;
            end else begin
               settle_d = settle_q - CNT_W'(1);
               state_d  = WAIT;
            end
         end
         RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ARMED;
            end
         end
         default: state_d = NOKEY;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= NOKEY;
         key_p_q      <= '0;
         key_x_q      <= '0;
         key_loaded_q <= 1'b0;
         core_d_q     <= '0;
         core_c_q     <= '0;
         core_en_q    <= 1'b0;
         settle_q     <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         key_p_q      <= key_p_d;
         key_x_q      <= key_x_d;
         key_loaded_q <= key_loaded_d;
         core_d_q     <= core_d_d;
         core_c_q     <= core_c_d;
         core_en_q    <= core_en_d;
         settle_q     <= settle_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
      end
   end

   assign key_loaded = key_loaded_q;
   assign core_p     = key_p_q;
   assign core_x     = key_x_q;
   assign core_d     = core_d_q;
   assign core_c     = core_c_q;
   assign core_en    = core_en_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;

endmodule
`default_nettype wire

// File: doc/lock_key_eval_ctrl.md
Name: lock_key_eval_ctrl

Overview:
Sequencer wrapped around the key-locked c499 SEC/DED corrector core. Input:
- 4 mux-select key bits p1..p4
- 10 XOR key bits X_1..X_10

It serially loads and atomically commits the 14-bit key. It then arbitrates evaluation requests onto the combinational core and returns the corrected 32-bit word through a valid/ready handshake. It sits between the key-provisioning/scan port and the locked datapath instance.

Parameters:
- KEY_W, 14, total key bits: MUX_W + XOR_W.
- MUX_W, 4, mux-select key bits (p1..p4).
- XOR_W, 10, XOR key-gate bits (X_1..X_10).
- SETTLE, 2, idle cycles between driving core inputs and capturing core outputs (0..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  serial key bit present.
- key_bit  in  1  serial key data, LSB-first.
- key_last  in  1  marks final key bit.
- key_ready  out  1  key bit accepted when key_valid&&key_ready.
- key_loaded  out  1  active key committed since reset.
- err_len  out  1  one-cycle pulse: bad key length.
- in_valid  in  1  evaluation request.
- in_data  in  32  data word (core N1..N125).
- in_chk  in  8  check bits (core N129..N136).
- in_ready  out  1  request accepted when in_valid&&in_ready.
- out_valid  out  1  result available.
- out_data  out  32  corrected word.
- out_ready  in  1  result consumed when out_valid&&out_ready.
- core_p  out  4  to core p1..p4.
- core_x  out  10  to core X_1..X_10.
- core_d  out  32  to core data inputs.
- core_c  out  8  to core check inputs.
- core_en  out  1  to core N137.
- core_q  in  32  from core N724..N755.

Behaviour:
- Clocking: clk only. rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - key_ready=0 during the rst cycle.
  - key_loaded=0, err_len=0, in_ready=0, out_valid=0, out_data=0.
  - core_p=0, core_x=0, core_d=0, core_c=0, core_en=0.
  - Shadow key, bit count and settle counter cleared; state NOKEY.
- States: NOKEY, ARMED, DRIVE, WAIT, RESP.
- Key vector bit mapping: bit0=p1 … bit3=p4, bit4=X_1 … bit13=X_10.
- key_ready=1 in NOKEY and ARMED; 0 in DRIVE/WAIT/RESP and in the rst cycle.
- Key accept:
  - Each accepted bit shifts into the shadow register at index cnt; cnt increments.
  - key_last with cnt==KEY_W-1: next cycle the shadow is copied atomically to core_p/core_x, key_loaded=1, cnt=0, state ARMED.
  - key_last with cnt!=KEY_W-1, or a KEY_W-th bit accepted without key_last:
    - err_len=1 for one cycle; shadow and cnt cleared.
    - Active key unchanged; state unchanged.
- Partial reload in ARMED: a key load in progress never alters core_p/core_x until commit. Evaluations stay permitted between accepted key bits; in_ready has priority only when key_valid=0 that cycle.
- in_ready=1 only in ARMED with key_valid=0.
- ARMED, request accepted → DRIVE:
  - core_d/core_c latched, core_en=1.
  - Settle counter loaded with SETTLE.
- DRIVE → WAIT next cycle. WAIT decrements the counter.
- Counter==0 in WAIT (or SETTLE=0 in DRIVE): out_data<=core_q, out_valid=1, core_en=0, state RESP.
- Latency: accept to out_valid = SETTLE+2 cycles.
- RESP: out_data stable and out_valid held until out_ready; on handshake out_valid=0 next cycle, state ARMED. Back-to-back: new request accepted the cycle after the consume at earliest.
- Requests in NOKEY are ignored: in_ready=0, no state change.
- rst mid-operation (any state): immediate return to reset values; the committed key is lost.
- Simultaneous key_last-commit and in_valid: commit wins; in_ready is 0 that cycle.

Decomposition:
- Package lock_ctrl_pkg:
  - KEY_W, MUX_W, XOR_W.
  - Key bit index constants (P1_IDX..X10_IDX).
  - State enum (NOKEY, ARMED, DRIVE, WAIT, RESP).
- Sub-module key_shift_reg:
  - Holds the shadow register, cnt, length check, err_len and commit strobe.
  - Parent holds the active key, FSM and datapath registers.

Test Plan:
- Load key 14'h2A5B LSB-first with key_last on bit 13 → key_loaded=1 two cycles after last accept; core_p=4'hB, core_x=10'h2A5 (bits 13..4 = 10'b1010100101); err_len never pulses.
- key_last on bit 9 → err_len=1 for exactly one cycle; key_loaded stays 0; core_p/core_x stay 0; a following full 14-bit load succeeds.
- Committed key, SETTLE=2, in_data=32'h0000_0001, in_chk=8'h00, core model returns 32'hDEAD_BEEF → core_en=1 from cycle+1; out_valid on cycle+4 with out_data=32'hDEAD_BEEF.
- out_ready held 0 for 5 cycles → out_valid and out_data stable, in_ready=0 throughout; single out_ready pulse clears out_valid next cycle and in_ready returns.
- in_valid=1 in NOKEY for 10 cycles → in_ready=0, core_en=0, out_valid=0.
- rst asserted in WAIT → next cycle all outputs 0, state NOKEY, key_loaded=0; a request is refused until a new key is committed.
